// File: rtl/i2c_slave.sv
// I2C target with a 16-byte register file: pointer-based writes, auto-incrementing
// reads, open-drain SDA drive and a combinational local read-back port.
module i2c_slave #(
    parameter logic [6:0]  SLV_ADDR    = 7'h48,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       busy,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [3:0] rd_sel,
    output logic [7:0] rd_data
);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StMack,
        StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       phase_q, phase_d;
    logic [3:0] ptr_q, ptr_d;
    logic       sda_out_q, sda_out_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [16];
    logic [7:0] rx_byte, rd_byte;
    logic       byte_done;

    // Synchronizers reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;

    assign rx_byte   = {shift_q[6:0], sda_s};
    assign rd_byte   = regs_q[ptr_q];
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            phase_q   <= 1'b0;
            ptr_q     <= '0;
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            ptr_q     <= ptr_d;
            sda_out_q <= sda_out_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file commits one clk after the strobe, from the strobe's own address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_stb_q) begin
            regs_q[wr_addr_q] <= wr_data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = StIdle;
        end else if (start_det) begin
            state_d = StAddr;
        end else begin
            case (state_q)
                StAddr: begin
                    if (byte_done) begin
                        state_d = (rx_byte[7:1] == SLV_ADDR) ? StAddrAck : StIgnore;
                    end
                end
                StAddrAck: begin
                    if (scl_fall && phase_q) state_d = shift_q[0] ? StRdata : StPtr;
                end
                StPtr:      if (byte_done) state_d = StPtrAck;
                StPtrAck:   if (scl_fall && phase_q) state_d = StWdata;
                StWdata:    if (byte_done) state_d = StWdataAck;
                StWdataAck: if (scl_fall && phase_q) state_d = StWdata;
                StRdata:    if (scl_fall && bit_cnt_q == 3'd0) state_d = StMack;
                StMack: begin
                    if (scl_rise && sda_s) begin
                        state_d = StIgnore;
                    end else if (scl_fall && phase_q) begin
                        state_d = StRdata;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // phase_q marks the second half of a ninth-bit slot (ACK driven / master ACK seen).
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        phase_d   = phase_q;
        ptr_d     = ptr_q;
        sda_out_d = sda_out_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_det) begin
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start_det) begin
            sda_out_d = 1'b1;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        phase_d = 1'b0;
                        if (state_q == StPtr) ptr_d = rx_byte[3:0];
                        if (state_q == StWdata) begin
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            ptr_d     = ptr_q + 4'd1;
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_out_d = 1'b0;
                            phase_d   = 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            sda_out_d = 1'b1;
                            if (state_q == StAddrAck && shift_q[0]) begin
                                sda_out_d = rd_byte[7];
                                shift_d   = {rd_byte[6:0], 1'b0};
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_out_d = 1'b1;
                            phase_d   = 1'b0;
                        end else begin
                            sda_out_d = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                StMack: begin
                    if (scl_rise && !sda_s && !phase_q) begin
                        phase_d = 1'b1;
                        ptr_d   = ptr_q + 4'd1;
                    end
                    if (scl_fall && phase_q) begin
                        bit_cnt_d = '0;
                        sda_out_d = rd_byte[7];
                        shift_d   = {rd_byte[6:0], 1'b0};
                    end
                end
                default: sda_out_d = 1'b1;
            endcase
        end
    end

    assign o_sda   = sda_out_q;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_data = regs_q[rd_sel];

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, directed vector table and random
// transactions checked against a register-file/pointer model.
module tb_i2c_slave;

    localparam int unsigned Q = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       o_sda;
    logic       busy;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_sel;
    logic [7:0] rd_data;

    assign sda_bus = sda_m & o_sda;

    always #5 clk = ~clk;

    i2c_slave #(
        .SLV_ADDR   (7'h48),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_scl  (scl),
        .i_sda  (sda_bus),
        .o_sda  (o_sda),
        .busy   (busy),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_sel (rd_sel),
        .rd_data(rd_data)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr;
    logic [11:0] stb_q[$];
    logic [11:0] exp_stb_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_stb === 1'b1) stb_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [7:0] addr_byte;
        logic [7:0] ptr_byte;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         exp_ack;
        int         exp_stb;
        logic [3:0] sel0;
        logic [7:0] val0;
        logic [3:0] sel1;
        logic [7:0] val1;
    } wvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl = 1'b1; qwait(); qwait();
        sda_m = 1'b0; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl = 1'b1; qwait(); qwait();
        sda_m = 1'b1; qwait(); qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qwait();
        scl = 1'b1; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl = 1'b1; qwait();
        b = sda_bus; qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(nack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic check_reg(input string name, input logic [3:0] idx, input logic [7:0] exp);
        rd_sel = idx;
        @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_stb(input string name);
        check({name, "_stb_cnt"}, 32'(stb_q.size()), 32'(exp_stb_q.size()));
        for (int i = 0; i < exp_stb_q.size() && i < stb_q.size(); i++) begin
            check({name, "_stb"}, 32'(stb_q[i]), 32'(exp_stb_q[i]));
        end
        stb_q.delete();
        exp_stb_q.delete();
    endtask

    task automatic m_write(input logic [7:0] d);
        m_regs[m_ptr] = d;
        exp_stb_q.push_back({m_ptr, d});
        m_ptr = m_ptr + 4'd1;
    endtask

    task automatic read_n(input string name, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check({name, "_rdbyte"}, 32'(d), 32'(m_regs[m_ptr]));
            if (i != n - 1) m_ptr = m_ptr + 4'd1;
        end
    endtask

    initial begin
        wvec_t      vecs [4];
        logic       nack;
        logic [7:0] d;
        logic [7:0] p;
        logic [6:0] a7;
        int         n;
        int         kind;

        vecs[0] = '{"wr_basic", 8'h90, 8'h03, 8'hA5, 8'h5A, 1'b1, 2, 4'd3, 8'hA5, 4'd4, 8'h5A};
        vecs[1] = '{"mismatch", 8'h92, 8'h00, 8'h77, 8'h66, 1'b0, 0, 4'd0, 8'h00, 4'd3, 8'hA5};
        vecs[2] = '{"hi_ptr", 8'h90, 8'hF1, 8'h3C, 8'hC3, 1'b1, 2, 4'd1, 8'h3C, 4'd2, 8'hC3};
        vecs[3] = '{"wrap", 8'h90, 8'h0F, 8'h11, 8'h22, 1'b1, 2, 4'd15, 8'h11, 4'd0, 8'h22};

        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr  = 4'd0;
        rst_n  = 1'b0;
        scl    = 1'b1;
        sda_m  = 1'b1;
        rd_sel = 4'd0;
        repeat (5) @(negedge clk);
        check("rst_o_sda", 32'(o_sda), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed write vectors
        for (int v = 0; v < 4; v++) begin
            bus_start();
            write_byte(vecs[v].addr_byte, nack);
            check({vecs[v].name, "_addr_ack"}, 32'(nack), 32'(!vecs[v].exp_ack));
            check({vecs[v].name, "_busy"}, 32'(busy), 32'd1);
            write_byte(vecs[v].ptr_byte, nack);
            check({vecs[v].name, "_ptr_ack"}, 32'(nack), 32'(!vecs[v].exp_ack));
            write_byte(vecs[v].d0, nack);
            check({vecs[v].name, "_d0_ack"}, 32'(nack), 32'(!vecs[v].exp_ack));
            write_byte(vecs[v].d1, nack);
            check({vecs[v].name, "_d1_ack"}, 32'(nack), 32'(!vecs[v].exp_ack));
            bus_stop();
            repeat (4) @(negedge clk);
            check({vecs[v].name, "_busy_after"}, 32'(busy), 32'd0);
            check({vecs[v].name, "_o_sda_after"}, 32'(o_sda), 32'd1);
            check({vecs[v].name, "_stb_cnt"}, 32'(stb_q.size()), 32'(vecs[v].exp_stb));
            if (vecs[v].exp_stb == 2 && stb_q.size() == 2) begin
                check({vecs[v].name, "_stb0"}, 32'(stb_q[0]),
                      32'({vecs[v].ptr_byte[3:0], vecs[v].d0}));
                check({vecs[v].name, "_stb1"}, 32'(stb_q[1]),
                      32'({vecs[v].ptr_byte[3:0] + 4'd1, vecs[v].d1}));
            end
            stb_q.delete();
            check_reg({vecs[v].name, "_reg0"}, vecs[v].sel0, vecs[v].val0);
            check_reg({vecs[v].name, "_reg1"}, vecs[v].sel1, vecs[v].val1);
            if (vecs[v].exp_ack) begin
                m_ptr = vecs[v].ptr_byte[3:0];
                m_regs[m_ptr] = vecs[v].d0;
                m_ptr = m_ptr + 4'd1;
                m_regs[m_ptr] = vecs[v].d1;
                m_ptr = m_ptr + 4'd1;
            end
        end

        // Pointer wrapped to 1: a plain read continues from there
        bus_start();
        write_byte(8'h91, nack);
        check("wrapptr_addr_ack", 32'(nack), 32'd0);
        read_byte(1'b0, d);
        check("wrapptr_rd0", 32'(d), 32'h3C);
        read_byte(1'b1, d);
        check("wrapptr_rd1", 32'(d), 32'hC3);
        bus_stop();
        m_ptr = 4'd2;

        // Read with repeated START
        bus_start();
        write_byte(8'h90, nack);
        check("rs_addr_ack", 32'(nack), 32'd0);
        write_byte(8'h03, nack);
        check("rs_ptr_ack", 32'(nack), 32'd0);
        bus_start();
        write_byte(8'h91, nack);
        check("rs_raddr_ack", 32'(nack), 32'd0);
        read_byte(1'b0, d);
        check("rs_rd0", 32'(d), 32'hA5);
        read_byte(1'b1, d);
        check("rs_rd1", 32'(d), 32'h5A);
        check("rs_release_after_nack", 32'(o_sda), 32'd1);
        bus_stop();
        m_ptr = 4'd4;

        // STOP in the middle of a data byte discards it
        bus_start();
        write_byte(8'h90, nack);
        write_byte(8'h02, nack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        bus_stop();
        repeat (4) @(negedge clk);
        check("early_stop_stb", 32'(stb_q.size()), 32'd0);
        check("early_stop_o_sda", 32'(o_sda), 32'd1);
        check("early_stop_busy", 32'(busy), 32'd0);
        check_reg("early_stop_reg2", 4'd2, m_regs[2]);
        stb_q.delete();

        // Reset while the target drives the address ACK of a read
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(p_addr_bit(i));
        check("rst_mid_driving", 32'(o_sda), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_release", 32'(o_sda), 32'd1);
        sda_m = 1'b1;
        scl   = 1'b1;
        qwait();
        rst_n = 1'b1;
        qwait();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
        for (int i = 0; i < 16; i++) check_reg("rst_regs_clear", 4'(i), 8'h00);
        bus_start();
        write_byte(8'h90, nack);
        check("post_rst_addr_ack", 32'(nack), 32'd0);
        write_byte(8'h05, nack);
        m_ptr = 4'd5;
        write_byte(8'h99, nack);
        check("post_rst_data_ack", 32'(nack), 32'd0);
        m_write(8'h99);
        bus_stop();
        check_stb("post_rst");
        check_reg("post_rst_reg5", 4'd5, 8'h99);

        // Random transactions against the model
        for (int t = 0; t < 16; t++) begin
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 4));
            bus_start();
            if ($urandom_range(0, 4) == 0) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h48) a7 = 7'h49;
                write_byte({a7, 1'($urandom)}, nack);
                check("rnd_bad_addr_nack", 32'(nack), 32'd1);
            end else if (kind < 2) begin
                write_byte(8'h90, nack);
                check("rnd_w_addr_ack", 32'(nack), 32'd0);
                p = 8'($urandom);
                write_byte(p, nack);
                check("rnd_w_ptr_ack", 32'(nack), 32'd0);
                m_ptr = p[3:0];
                for (int i = 0; i < n; i++) begin
                    d = 8'($urandom);
                    write_byte(d, nack);
                    check("rnd_w_data_ack", 32'(nack), 32'd0);
                    m_write(d);
                end
            end else begin
                if (kind == 2) begin
                    write_byte(8'h90, nack);
                    check("rnd_r_addr_ack", 32'(nack), 32'd0);
                    p = 8'($urandom);
                    write_byte(p, nack);
                    check("rnd_r_ptr_ack", 32'(nack), 32'd0);
                    m_ptr = p[3:0];
                    bus_start();
                end
                write_byte(8'h91, nack);
                check("rnd_r_raddr_ack", 32'(nack), 32'd0);
                read_n("rnd_r", n);
            end
            bus_stop();
            repeat (4) @(negedge clk);
            check("rnd_busy_after", 32'(busy), 32'd0);
            check_stb("rnd");
            p = 8'($urandom);
            check_reg("rnd_reg", p[3:0], m_regs[p[3:0]]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic p_addr_bit(input int i);
        logic [7:0] rd_addr;
        rd_addr = 8'h91;
        return rd_addr[i];
    endfunction

endmodule
